// File: rtl/clip_pkg.sv
// clip_pkg: shared state encoding, record layout and object-type constants for clip_fetch
package clip_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_RD,
        S_LATCH,
        S_EDGE,
        S_NEXT,
        S_DONE
    } state_t;

    localparam int VLD_BIT = 143;
    localparam int TYPE_HI = 142;
    localparam int TYPE_LO = 141;
    localparam int COL_HI  = 140;
    localparam int COL_LO  = 133;
    localparam int VTX_HI  = 127;

    localparam logic [1:0] T_POINT = 2'd0;
    localparam logic [1:0] T_LINE  = 2'd1;
    localparam logic [1:0] T_TRI   = 2'd2;
    localparam logic [1:0] T_QUAD  = 2'd3;

    localparam int SCR_W_DEF = 640;
    localparam int SCR_H_DEF = 480;

    function automatic logic [2:0] edge_cnt(input logic [1:0] t);
        return t == T_TRI ? 3'd3 : t == T_QUAD ? 3'd4 : 3'd1;
    endfunction

endpackage

// File: rtl/clip_reject.sv
// clip_reject: drops a segment whose endpoints both lie strictly beyond the same screen edge
module clip_reject
    import clip_pkg::*;
#(
    parameter int SCR_W = SCR_W_DEF,
    parameter int SCR_H = SCR_H_DEF
) (
    input  logic signed [15:0] x0,
    input  logic signed [15:0] y0,
    input  logic signed [15:0] x1,
    input  logic signed [15:0] y1,
    output logic               reject
);

    localparam logic signed [15:0] XMAX = 16'(SCR_W - 1);
    localparam logic signed [15:0] YMAX = 16'(SCR_H - 1);

    assign reject = (x0 < 16'sd0 && x1 < 16'sd0) || (x0 > XMAX && x1 > XMAX) ||
                    (y0 < 16'sd0 && y1 < 16'sd0) || (y0 > YMAX && y1 > YMAX);

endmodule

// File: rtl/clip_fetch.sv
// clip_fetch: walks object memory, unpacks edges, rejects off-screen ones, streams segments
module clip_fetch
    import clip_pkg::*;
#(
    parameter int SCR_W = SCR_W_DEF,
    parameter int SCR_H = SCR_H_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               changed,
    input  logic               writing,
    output logic               clr_changed,
    output logic               reading,
    output logic               mem_rd_en,
    output logic [4:0]         mem_addr,
    input  logic [143:0]       obj_in,
    output logic               seg_vld,
    input  logic               seg_rdy,
    output logic signed [15:0] seg_x0,
    output logic signed [15:0] seg_y0,
    output logic signed [15:0] seg_x1,
    output logic signed [15:0] seg_y1,
    output logic [7:0]         seg_color,
    output logic               frame_done
);

    state_t state, nxt;
    logic [4:0] slot;
    logic [1:0] eidx, nxt_edge, ia, ib, typ, src_typ;
    logic [7:0] col, src_col;
    logic [2:0] cnt;
    logic signed [15:0] vx [4];
    logic signed [15:0] vy [4];
    logic signed [15:0] sx [4];
    logic signed [15:0] sy [4];
    logic signed [15:0] ax, ay, bx, by;
    logic rej;

    // Edge source: straight from memory while latching, otherwise the held object.
    // The segment register is loaded one cycle ahead so seg_vld lines up with EDGE.
    always_comb begin
        src_typ = state == S_LATCH ? obj_in[TYPE_HI:TYPE_LO] : typ;
        src_col = state == S_LATCH ? obj_in[COL_HI:COL_LO] : col;
        for (int i = 0; i < 4; i++) begin
            sx[i] = state == S_LATCH ? obj_in[VTX_HI - 32*i -: 16] : vx[i];
            sy[i] = state == S_LATCH ? obj_in[VTX_HI - 16 - 32*i -: 16] : vy[i];
        end
        cnt      = edge_cnt(src_typ);
        nxt_edge = state == S_EDGE ? (seg_vld && !seg_rdy ? eidx : eidx + 2'd1) : 2'd0;
        ia       = nxt_edge;
        ib       = src_typ == T_POINT ? 2'd0 :
                   src_typ == T_LINE ? 2'd1 :
                   {1'b0, nxt_edge} == cnt - 3'd1 ? 2'd0 : nxt_edge + 2'd1;
        ax = sx[ia];
        ay = sy[ia];
        bx = sx[ib];
        by = sy[ib];
    end

    clip_reject #(.SCR_W(SCR_W), .SCR_H(SCR_H)) u_reject (
        .x0(ax), .y0(ay), .x1(bx), .y1(by), .reject(rej)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= nxt;
    end

    // Next-state: EDGE holds while an offered segment is stalled
    always_comb begin
        nxt = S_IDLE;
        unique case (state)
            S_IDLE:  nxt = changed && !writing ? S_ARM : S_IDLE;
            S_ARM:   nxt = S_RD;
            S_RD:    nxt = S_LATCH;
            S_LATCH: nxt = obj_in[VLD_BIT] ? S_EDGE : S_NEXT;
            S_EDGE:  nxt = seg_vld && !seg_rdy ? S_EDGE :
                           {1'b0, eidx} == cnt - 3'd1 ? S_NEXT : S_EDGE;
            S_NEXT:  nxt = slot == 5'd31 ? S_DONE : S_RD;
            S_DONE:  nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    // Handshake outputs to the matrix unit and video memory
    always_comb begin
        reading     = state != S_IDLE;
        clr_changed = state == S_ARM;
        mem_rd_en   = state == S_RD;
        mem_addr    = state == S_RD ? slot : 5'd0;
        frame_done  = state == S_DONE;
    end

    // Slot/edge counters, object capture and registered segment output
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot      <= '0;
            eidx      <= '0;
            typ       <= '0;
            col       <= '0;
            for (int i = 0; i < 4; i++) begin
                vx[i] <= '0;
                vy[i] <= '0;
            end
            seg_vld   <= 1'b0;
            seg_x0    <= '0;
            seg_y0    <= '0;
            seg_x1    <= '0;
            seg_y1    <= '0;
            seg_color <= '0;
        end else begin
            slot <= state == S_ARM ? 5'd0 : state == S_NEXT ? slot + 5'd1 : slot;
            eidx <= nxt_edge;
            if (state == S_LATCH) begin
                typ <= src_typ;
                col <= src_col;
                for (int i = 0; i < 4; i++) begin
                    vx[i] <= sx[i];
                    vy[i] <= sy[i];
                end
            end
            seg_vld   <= nxt == S_EDGE && !rej;
            seg_x0    <= ax;
            seg_y0    <= ay;
            seg_x1    <= bx;
            seg_y1    <= by;
            seg_color <= src_col;
        end
    end

endmodule

// File: tb/tb_clip_fetch.sv
// tb_clip_fetch: randomized and directed checks of clip_fetch against an object-list model
module tb_clip_fetch;

    localparam int W = 640;
    localparam int H = 480;

    logic clk = 0, rst = 1, changed = 0, writing = 0, seg_rdy = 0;
    logic [143:0] obj_in = '0;
    logic clr_changed, reading, mem_rd_en, seg_vld, frame_done;
    logic [4:0] mem_addr;
    logic signed [15:0] seg_x0, seg_y0, seg_x1, seg_y1;
    logic [7:0] seg_color;

    logic [143:0] mem [32];
    logic [71:0] got [$];
    logic [71:0] exp_q [$];
    int n_cmp = 0, n_bad = 0;
    int wn, cy, cn, rn, len;

    clip_fetch #(.SCR_W(W), .SCR_H(H)) dut (
        .clk(clk), .rst(rst), .changed(changed), .writing(writing),
        .clr_changed(clr_changed), .reading(reading), .mem_rd_en(mem_rd_en),
        .mem_addr(mem_addr), .obj_in(obj_in), .seg_vld(seg_vld), .seg_rdy(seg_rdy),
        .seg_x0(seg_x0), .seg_y0(seg_y0), .seg_x1(seg_x1), .seg_y1(seg_y1),
        .seg_color(seg_color), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // video memory: one-cycle read latency
    always @(posedge clk) if (mem_rd_en) obj_in <= mem[mem_addr];

    function automatic logic [143:0] rec(input int t, c, x0, y0, x1, y1, x2, y2, x3, y3);
        return {1'b1, 2'(t), 8'(c), 5'b10101, 16'(x0), 16'(y0), 16'(x1), 16'(y1),
                16'(x2), 16'(y2), 16'(x3), 16'(y3)};
    endfunction

    function automatic int rv();
        return int'($urandom_range(0, 1100)) - 200;
    endfunction

    function automatic bit off(input int ax, ay, bx, by);
        return (ax < 0 && bx < 0) || (ax >= W && bx >= W) || (ay < 0 && by < 0) || (ay >= H && by >= H);
    endfunction

    // expected segment list and no-stall walk length from the memory image
    function automatic int model();
        int n, a, b, t, cycles;
        int vx [4];
        int vy [4];
        logic [143:0] r;
        exp_q = {};
        cycles = 98;
        for (int s = 0; s < 32; s++) begin
            r = mem[s];
            if (!r[143]) continue;
            t = int'(r[142:141]);
            n = t == 2 ? 3 : t == 3 ? 4 : 1;
            cycles += n;
            for (int i = 0; i < 4; i++) begin
                vx[i] = int'($signed(r[127 - 32*i -: 16]));
                vy[i] = int'($signed(r[111 - 32*i -: 16]));
            end
            for (int e = 0; e < n; e++) begin
                a = t == 1 ? 0 : e;
                b = t == 0 ? 0 : t == 1 ? 1 : (e + 1) % n;
                if (!off(vx[a], vy[a], vx[b], vy[b]))
                    exp_q.push_back({16'(vx[a]), 16'(vy[a]), 16'(vx[b]), 16'(vy[b]), r[140:133]});
            end
        end
        return cycles;
    endfunction

    task automatic clear_mem();
        for (int s = 0; s < 32; s++) mem[s] = {1'b0, $urandom, $urandom, $urandom, $urandom, 15'h0};
    endtask

    // run one walk as matrix unit + rasterizer; stall_idx stalls that segment for 5 cycles
    task automatic run_walk(input int rnd_rdy, input int stall_idx,
                            output int wait_n, output int cyc, output int clr_n, output int rd_n);
        int stalled;
        logic [72:0] cur, snap;
        got = {};
        changed = 1;
        wait_n = 0; cyc = 0; clr_n = 0; rd_n = 0; stalled = 0; snap = '0;
        do begin
            @(negedge clk);
            wait_n++;
        end while (!reading && wait_n < 50);
        n_cmp++;
        if (!reading) begin
            n_bad++;
            $display("FAIL walk_start: reading=%0b after %0d cycles, required 1", reading, wait_n);
            return;
        end
        cyc = 1;
        forever begin
            cur = {seg_vld, seg_x0, seg_y0, seg_x1, seg_y1, seg_color};
            if (clr_changed) begin clr_n++; changed = 0; end
            if (mem_rd_en) rd_n++;
            if (stall_idx >= 0 && got.size() == stall_idx && seg_vld && stalled < 5) begin
                seg_rdy = 0;
                if (stalled == 0) snap = cur;
                else begin
                    n_cmp++;
                    if (cur !== snap) begin
                        n_bad++;
                        $display("FAIL stall_hold%0d: got %h required %h", stalled, cur, snap);
                    end
                end
                stalled++;
            end else seg_rdy = rnd_rdy != 0 ? 1'($urandom_range(0, 1)) : 1'b1;
            if (seg_vld && seg_rdy) got.push_back(cur[71:0]);
            if (frame_done || cyc >= 4000) break;
            @(negedge clk);
            cyc++;
        end
        n_cmp++;
        if (!frame_done) begin
            n_bad++;
            $display("FAIL walk_done: no frame_done within %0d cycles", cyc);
        end
        if (stall_idx >= 0) begin
            n_cmp++;
            if (stalled != 5) begin
                n_bad++;
                $display("FAIL stall_cycles: got %0d required 5", stalled);
            end
        end
        @(negedge clk);
        n_cmp++;
        if ({reading, frame_done} !== 2'b00) begin
            n_bad++;
            $display("FAIL walk_end: reading,frame_done=%b required 00", {reading, frame_done});
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({clr_changed, reading, mem_rd_en, mem_addr, seg_vld, frame_done} !== 10'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %b required 0", {clr_changed, reading, mem_rd_en, mem_addr, seg_vld, frame_done});
        end
        n_cmp++;
        if ({seg_x0, seg_y0, seg_x1, seg_y1, seg_color} !== 72'b0) begin
            n_bad++;
            $display("FAIL reset_seg: got %h required 0", {seg_x0, seg_y0, seg_x1, seg_y1, seg_color});
        end
        rst = 0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (reading !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_idle: reading=%b required 0", reading);
        end
    endtask

    task automatic test_single_line();
        clear_mem();
        mem[3] = rec(1, 8'h2A, 10, 10, 100, 50, 7, 7, 7, 7);
        len = model();
        run_walk(0, -1, wn, cy, cn, rn);
        n_cmp++;
        if (got.size() != 1 || got[0] !== {16'd10, 16'd10, 16'd100, 16'd50, 8'h2A}) begin
            n_bad++;
            $display("FAIL line_seg: got %0d segs first %h required 1 seg %h", got.size(), got.size() ? got[0] : 72'h0, {16'd10, 16'd10, 16'd100, 16'd50, 8'h2A});
        end
        n_cmp++;
        if (cy != 99 || len != 99) begin n_bad++; $display("FAIL line_cycles: got %0d required 99", cy); end
        n_cmp++;
        if (cn != 1) begin n_bad++; $display("FAIL line_clr: got %0d pulses required 1", cn); end
        n_cmp++;
        if (rn != 32) begin n_bad++; $display("FAIL line_reads: got %0d required 32", rn); end
        n_cmp++;
        if (wn != 1) begin n_bad++; $display("FAIL line_start: got %0d required 1", wn); end
    endtask

    task automatic test_triangle_stall();
        clear_mem();
        mem[0] = rec(2, 8'h11, 0, 0, 50, 0, 0, 50, 0, 0);
        len = model();
        run_walk(0, 1, wn, cy, cn, rn);
        n_cmp++;
        if (got.size() != 3) begin
            n_bad++;
            $display("FAIL tri_count: got %0d required 3", got.size());
        end else foreach (got[i]) begin
            n_cmp++;
            if (got[i] !== exp_q[i]) begin n_bad++; $display("FAIL tri_seg%0d: got %h required %h", i, got[i], exp_q[i]); end
        end
        n_cmp++;
        if (cy != len + 5) begin n_bad++; $display("FAIL tri_cycles: got %0d required %0d", cy, len + 5); end
    endtask

    task automatic test_quad_offscreen();
        clear_mem();
        mem[7] = rec(3, 8'h33, -10, 0, -5, 100, -300, 200, -1, 479);
        len = model();
        run_walk(0, -1, wn, cy, cn, rn);
        n_cmp++;
        if (got.size() != 0) begin n_bad++; $display("FAIL quad_off_count: got %0d required 0", got.size()); end
        n_cmp++;
        if (cy != 102) begin n_bad++; $display("FAIL quad_off_cycles: got %0d required 102", cy); end
    endtask

    task automatic test_line_cross();
        clear_mem();
        mem[31] = rec(1, 8'h05, -20, 10, 20, 10, 0, 0, 0, 0);
        run_walk(0, -1, wn, cy, cn, rn);
        n_cmp++;
        if (got.size() != 1 || got[0] !== {-16'sd20, 16'sd10, 16'sd20, 16'sd10, 8'h05}) begin
            n_bad++;
            $display("FAIL cross_seg: got %0d segs first %h", got.size(), got.size() ? got[0] : 72'h0);
        end
    endtask

    task automatic test_boundary();
        clear_mem();
        mem[0] = rec(0, 1, 639, 479, 0, 0, 0, 0, 0, 0);
        mem[1] = rec(0, 2, 640, 0, 0, 0, 0, 0, 0, 0);
        mem[2] = rec(0, 3, -1, 5, 0, 0, 0, 0, 0, 0);
        mem[3] = rec(0, 4, 0, 0, 0, 0, 0, 0, 0, 0);
        mem[4] = rec(1, 5, 640, 0, 639, 0, 0, 0, 0, 0);
        mem[5] = rec(1, 6, 0, 480, 5, 481, 0, 0, 0, 0);
        len = model();
        run_walk(0, -1, wn, cy, cn, rn);
        n_cmp++;
        if (got.size() != 3 || exp_q.size() != 3) begin
            n_bad++;
            $display("FAIL bound_count: got %0d required 3", got.size());
        end else foreach (got[i]) begin
            n_cmp++;
            if (got[i] !== exp_q[i]) begin n_bad++; $display("FAIL bound_seg%0d: got %h required %h", i, got[i], exp_q[i]); end
        end
        n_cmp++;
        if (cy != len) begin n_bad++; $display("FAIL bound_cycles: got %0d required %0d", cy, len); end
    endtask

    task automatic test_writing();
        clear_mem();
        mem[0] = rec(1, 8'h44, 1, 2, 3, 4, 0, 0, 0, 0);
        changed = 1;
        writing = 1;
        repeat (10) begin
            @(negedge clk);
            n_cmp++;
            if ({reading, mem_rd_en} !== 2'b00) begin
                n_bad++;
                $display("FAIL writing_hold: reading,mem_rd_en=%b required 00", {reading, mem_rd_en});
            end
        end
        writing = 0;
        run_walk(0, -1, wn, cy, cn, rn);
        n_cmp++;
        if (wn != 1) begin n_bad++; $display("FAIL writing_start: got %0d cycles required 1", wn); end
        n_cmp++;
        if (got.size() != 1) begin n_bad++; $display("FAIL writing_count: got %0d required 1", got.size()); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 20; it++) begin
            for (int s = 0; s < 32; s++)
                mem[s] = $urandom_range(0, 1) != 0 ?
                         rec(int'($urandom_range(0, 3)), int'($urandom_range(0, 255)), rv(), rv(), rv(), rv(), rv(), rv(), rv(), rv()) :
                         {1'b0, $urandom, $urandom, $urandom, $urandom, 15'h0};
            len = model();
            run_walk(1, -1, wn, cy, cn, rn);
            n_cmp++;
            if (got.size() != exp_q.size()) begin
                n_bad++;
                $display("FAIL rand%0d_count: got %0d required %0d", it, got.size(), exp_q.size());
            end else foreach (got[i]) begin
                n_cmp++;
                if (got[i] !== exp_q[i]) begin n_bad++; $display("FAIL rand%0d_seg%0d: got %h required %h", it, i, got[i], exp_q[i]); end
            end
            n_cmp++;
            if (cn != 1 || rn != 32) begin n_bad++; $display("FAIL rand%0d_ctrl: clr %0d reads %0d required 1 and 32", it, cn, rn); end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        clear_mem();
        mem[2] = rec(1, 8'h77, 5, 5, 6, 6, 0, 0, 0, 0);
        changed = 1;
        seg_rdy = 0;
        n = 0;
        do begin
            @(negedge clk);
            if (clr_changed) changed = 0;
            n++;
        end while (!seg_vld && n < 200);
        n_cmp++;
        if (!seg_vld) begin n_bad++; $display("FAIL midrst_reach: seg_vld=0 after %0d cycles, required 1", n); end
        rst = 1;
        #1;
        n_cmp++;
        if ({clr_changed, reading, mem_rd_en, mem_addr, seg_vld, frame_done, seg_x0, seg_y0, seg_x1, seg_y1, seg_color} !== 82'b0) begin
            n_bad++;
            $display("FAIL midrst_outputs: got %h required 0", {clr_changed, reading, mem_rd_en, mem_addr, seg_vld, frame_done, seg_x0, seg_y0, seg_x1, seg_y1, seg_color});
        end
        @(negedge clk);
        rst = 0;
        repeat (3) begin
            @(negedge clk);
            n_cmp++;
            if ({reading, frame_done} !== 2'b00) begin
                n_bad++;
                $display("FAIL midrst_idle: reading,frame_done=%b required 00", {reading, frame_done});
            end
        end
        run_walk(0, -1, wn, cy, cn, rn);
        n_cmp++;
        if (got.size() != 1 || got[0] !== {16'd5, 16'd5, 16'd6, 16'd6, 8'h77}) begin
            n_bad++;
            $display("FAIL midrst_restart: got %0d segs", got.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_line();
        test_triangle_stall();
        test_quad_offscreen();
        test_line_cross();
        test_boundary();
        test_writing();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
